// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-token constants, tracker state enum and the symbol decode
// function shared by the encoder and decoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} align_state_t;

    typedef struct packed {
        logic       is_token;
        logic [1:0] code;
        logic [7:0] data;
    } tmds_dec_t;

    function automatic tmds_dec_t tmds_decode(input logic [9:0] sym);
        tmds_dec_t  r;
        logic [7:0] d;
        logic [7:0] pix;
        d = sym[9] ? ~sym[7:0] : sym[7:0];
        pix[0] = d[0];
        for (int i = 1; i < 8; i++)
            pix[i] = sym[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
        r.is_token = (sym == CTRL_TOKEN_00) || (sym == CTRL_TOKEN_01) ||
                     (sym == CTRL_TOKEN_10) || (sym == CTRL_TOKEN_11);
        r.code = (sym == CTRL_TOKEN_01) ? 2'b01 :
                 (sym == CTRL_TOKEN_10) ? 2'b10 :
                 (sym == CTRL_TOKEN_11) ? 2'b11 : 2'b00;
        r.data = r.is_token ? 8'h00 : pix;
        return r;
    endfunction

endpackage

// File: rtl/tmds_token_aligner.sv
// tmds_token_aligner: counts control-token runs and steers the deserializer word
// boundary with bit-slip requests until a run is seen, then watches for loss of lock.
module tmds_token_aligner
    import tmds_pkg::*;
#(
    parameter int TOKEN_RUN     = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_HOLDOFF  = 16,
    parameter int LOSS_WINDOW   = 16384
) (
    input  logic pix_clock,
    input  logic reset,
    input  logic is_token,
    output logic aligned,
    output logic bitslip
);

    localparam int RW = $clog2(TOKEN_RUN + 1);
    localparam int WW = $clog2(SEARCH_WINDOW);
    localparam int HW = $clog2(SLIP_HOLDOFF);
    localparam int LW = $clog2(LOSS_WINDOW);
    localparam logic [RW-1:0] RUN_MAX   = RW'(TOKEN_RUN);
    localparam logic [RW-1:0] RUN_LAST  = RW'(TOKEN_RUN - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(SEARCH_WINDOW - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SLIP_HOLDOFF - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_WINDOW - 1);

    align_state_t  r_state, w_next;
    logic [RW-1:0] r_run;
    logic [WW-1:0] r_win;
    logic [HW-1:0] r_hold;
    logic [LW-1:0] r_loss;
    logic          r_bitslip;
    logic          w_slip;
    logic          w_run_hit;

    // a run only counts once, on the cycle the counter climbs to TOKEN_RUN
    assign w_run_hit = is_token && (r_run == RUN_LAST) && (r_state != SLIP_WAIT);

    always_comb begin
        w_next = r_state;
        w_slip = 1'b0;
        unique case (r_state)
            SEARCH: begin
                if (w_run_hit)
                    w_next = LOCKED;
                else if (r_win == WIN_LAST) begin
                    w_next = SLIP_WAIT;
                    w_slip = 1'b1;
                end
            end
            SLIP_WAIT: w_next = (r_hold == HOLD_LAST) ? SEARCH : SLIP_WAIT;
            LOCKED:    w_next = (!w_run_hit && r_loss == LOSS_LAST) ? SEARCH : LOCKED;
            default:   w_next = SEARCH;
        endcase
    end

    always_ff @(posedge pix_clock) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_run     <= '0;
            r_win     <= '0;
            r_hold    <= '0;
            r_loss    <= '0;
            r_bitslip <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bitslip <= w_slip;
            r_run     <= (!is_token || r_state == SLIP_WAIT || w_next == SLIP_WAIT) ? '0 :
                         (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
            r_win     <= (r_state == SEARCH && w_next == SEARCH) ? r_win + 1'b1 : '0;
            r_hold    <= (r_state == SLIP_WAIT && w_next == SLIP_WAIT) ? r_hold + 1'b1 : '0;
            r_loss    <= (r_state == LOCKED && w_next == LOCKED && !w_run_hit) ? r_loss + 1'b1 : '0;
        end
    end

    assign aligned = (r_state == LOCKED);
    assign bitslip = r_bitslip;

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: two-stage TMDS symbol decoder (pixel data, control code, blanking)
// with a word-alignment tracker driven from the stage-1 symbol.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int TOKEN_RUN     = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_HOLDOFF  = 16,
    parameter int LOSS_WINDOW   = 16384
) (
    input  logic       pix_clock,
    input  logic       reset,
    input  logic [9:0] symbol,
    output logic [7:0] data,
    output logic [1:0] control_data,
    output logic       blanking,
    output logic       aligned,
    output logic       bitslip
);

    logic [9:0] r_sym;
    logic [7:0] r_data;
    logic [1:0] r_ctrl;
    logic       r_blank;
    tmds_dec_t  w_dec;

    assign w_dec = tmds_decode(r_sym);

    always_ff @(posedge pix_clock) begin
        if (reset) begin
            r_sym   <= '0;
            r_data  <= '0;
            r_ctrl  <= 2'b00;
            r_blank <= 1'b1;
        end else begin
            r_sym   <= symbol;
            r_data  <= w_dec.data;
            r_ctrl  <= w_dec.is_token ? w_dec.code : r_ctrl;
            r_blank <= w_dec.is_token;
        end
    end

    tmds_token_aligner #(
        .TOKEN_RUN    (TOKEN_RUN),
        .SEARCH_WINDOW(SEARCH_WINDOW),
        .SLIP_HOLDOFF (SLIP_HOLDOFF),
        .LOSS_WINDOW  (LOSS_WINDOW)
    ) u_aligner (
        .pix_clock(pix_clock),
        .reset    (reset),
        .is_token (w_dec.is_token),
        .aligned  (aligned),
        .bitslip  (bitslip)
    );

    assign data         = r_data;
    assign control_data = r_ctrl;
    assign blanking     = r_blank;

endmodule
